// File: rtl/kw_reset_sequencer.sv
// Ordered reset release for DOMAINS downstream domains: hold, then release one
// domain at a time, waiting for its ready (with optional timeout) before the next.
module kw_reset_sequencer #(
  parameter int DOMAINS     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int DELAY       = 8,
  parameter int TIMEOUT     = 255,
  localparam int IDX_W      = (DOMAINS > 2) ? $clog2(DOMAINS) : 1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               testmode,
  input  logic               i_sw_reset,
  input  logic [DOMAINS-1:0] i_ready,
  output logic [DOMAINS-1:0] o_reset_n,
  output logic               o_done,
  output logic               o_error,
  output logic [IDX_W-1:0]   o_err_domain
);

  localparam int MAX_HD = (HOLD_CYCLES > DELAY) ? HOLD_CYCLES : DELAY;
  localparam int MAX_C  = (MAX_HD > TIMEOUT) ? MAX_HD : TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_GAP        = 3'd2,
    ST_DONE       = 3'd3,
    ST_ERROR      = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [DOMAINS-1:0]   rst_n_r, rst_n_s;
  logic                 done_r, done_s;
  logic                 error_r, error_s;
  logic [IDX_W-1:0]     err_dom_r, err_dom_s;

  function automatic logic [DOMAINS-1:0] domain_bit(input logic [IDX_W-1:0] k);
    logic [DOMAINS-1:0] m;
    m    = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  // State and output registers
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= ST_HOLD;
      idx_r     <= '0;
      cnt_r     <= '0;
      rst_n_r   <= '0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      err_dom_r <= '0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      rst_n_r   <= rst_n_s;
      done_r    <= done_s;
      error_r   <= error_s;
      err_dom_r <= err_dom_s;
    end
  end

  // Next-state and next-output logic; software re-sequence overrides everything
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    rst_n_s   = rst_n_r;
    done_s    = done_r;
    error_s   = error_r;
    err_dom_s = err_dom_r;
    if (i_sw_reset) begin
      state_s   = ST_HOLD;
      idx_s     = '0;
      cnt_s     = '0;
      rst_n_s   = '0;
      done_s    = 1'b0;
      error_s   = 1'b0;
      err_dom_s = '0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          rst_n_s = '0;
          if (cnt_r == HOLD_LAST) begin
            rst_n_s = domain_bit('0);
            idx_s   = '0;
            cnt_s   = '0;
            state_s = ST_WAIT_READY;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_READY: begin
          // Ready is checked before the timeout so a same-edge arrival wins
          if (i_ready[idx_r]) begin
            if (idx_r == IDX_LAST) begin
              done_s  = 1'b1;
              state_s = ST_DONE;
            end else begin
              cnt_s   = '0;
              state_s = ST_GAP;
            end
          end else if (TIMEOUT != 0) begin
            if (cnt_r == TO_LAST) begin
              error_s   = 1'b1;
              err_dom_s = idx_r;
              rst_n_s   = '0;
              state_s   = ST_ERROR;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_GAP: begin
          if (cnt_r == DELAY_LAST) begin
            idx_s   = idx_r + IDX_ONE;
            rst_n_s = rst_n_r | domain_bit(idx_r + IDX_ONE);
            cnt_s   = '0;
            state_s = ST_WAIT_READY;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        ST_ERROR: begin
          state_s = ST_ERROR;
        end
        default: begin
          state_s   = ST_HOLD;
          idx_s     = '0;
          cnt_s     = '0;
          rst_n_s   = '0;
          done_s    = 1'b0;
          error_s   = 1'b0;
          err_dom_s = '0;
        end
      endcase
    end
  end

  assign o_reset_n    = testmode ? {DOMAINS{~i_reset}} : rst_n_r;
  assign o_done       = done_r;
  assign o_error      = error_r;
  assign o_err_domain = err_dom_r;

endmodule

// File: tb/tb_kw_reset_sequencer.sv
// Directed bench for kw_reset_sequencer: checkpoint table for nominal/timeout
// runs plus hand-written sequences for sw reset, async reset, testmode, no-timeout.
module tb_kw_reset_sequencer;

  logic       clock = 1'b0;
  logic       clk_en = 1'b1;
  logic       i_reset = 1'b0;
  logic       testmode = 1'b0;
  logic       i_sw_reset = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic [3:0] i_ready;
  logic [3:0] o_reset_n;
  logic       o_done;
  logic       o_error;
  logic [1:0] o_err_domain;

  logic       nt_reset = 1'b1;
  logic [3:0] nt_mask = 4'b0000;
  logic [3:0] nt_ready;
  logic [3:0] nt_rn;
  logic       nt_done;
  logic       nt_err;
  logic [1:0] nt_dom;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  assign i_ready  = o_reset_n & mask;
  assign nt_ready = nt_rn & nt_mask;

  kw_reset_sequencer #(.DOMAINS(4), .HOLD_CYCLES(4), .DELAY(3), .TIMEOUT(10)) dut (
    .clock(clock), .i_reset(i_reset), .testmode(testmode), .i_sw_reset(i_sw_reset),
    .i_ready(i_ready), .o_reset_n(o_reset_n), .o_done(o_done), .o_error(o_error),
    .o_err_domain(o_err_domain)
  );

  kw_reset_sequencer #(.DOMAINS(4), .HOLD_CYCLES(4), .DELAY(3), .TIMEOUT(0)) dut_nt (
    .clock(clock), .i_reset(nt_reset), .testmode(1'b0), .i_sw_reset(1'b0),
    .i_ready(nt_ready), .o_reset_n(nt_rn), .o_done(nt_done), .o_error(nt_err),
    .o_err_domain(nt_dom)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clock = ~clock;
    end
  end

  typedef struct {
    logic [3:0] mask;
    int         edge_n;
    logic [3:0] exp_rn;
    logic       exp_done;
    logic       exp_err;
    logic [1:0] exp_dom;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edge_cnt++;
  endtask

  task automatic step_to(input int n);
    while (edge_cnt < n) step();
  endtask

  // Hold reset over two edges and release it so the next rising edge is edge 1
  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    @(negedge clock);
    i_reset = 1'b0;
    edge_cnt = 0;
  endtask

  initial begin
    vecs[0]  = '{4'b1111,  3, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111,  4, 4'b0001, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{4'b1111,  7, 4'b0001, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{4'b1111,  8, 4'b0011, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{4'b1111, 11, 4'b0011, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{4'b1111, 12, 4'b0111, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{4'b1111, 16, 4'b1111, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{4'b1111, 17, 4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{4'b1111, 30, 4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{4'b1011, 12, 4'b0111, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{4'b1011, 21, 4'b0111, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{4'b1011, 22, 4'b0000, 1'b0, 1'b1, 2'd2};
    vecs[12] = '{4'b1011, 50, 4'b0000, 1'b0, 1'b1, 2'd2};
    vecs[13] = '{4'b1011, 72, 4'b0000, 1'b0, 1'b1, 2'd2};

    #1 i_reset = 1'b1;
    #1;
    chk("reset_rn", {28'd0, o_reset_n}, 32'h0);
    chk("reset_done", {31'd0, o_done}, 32'h0);
    chk("reset_err", {31'd0, o_error}, 32'h0);
    chk("reset_dom", {30'd0, o_err_domain}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].mask !== mask || vecs[i].edge_n <= edge_cnt) begin
        mask = vecs[i].mask;
        do_reset();
      end
      step_to(vecs[i].edge_n);
      chk("tbl_rn", {28'd0, o_reset_n}, {28'd0, vecs[i].exp_rn});
      chk("tbl_done", {31'd0, o_done}, {31'd0, vecs[i].exp_done});
      chk("tbl_err", {31'd0, o_error}, {31'd0, vecs[i].exp_err});
      chk("tbl_dom", {30'd0, o_err_domain}, {30'd0, vecs[i].exp_dom});
    end

    // Software re-sequence on edges 10-11
    mask = 4'b1111;
    do_reset();
    step_to(9);
    i_sw_reset = 1'b1;
    step();
    chk("sw_rn10", {28'd0, o_reset_n}, 32'h0);
    chk("sw_done10", {31'd0, o_done}, 32'h0);
    step();
    i_sw_reset = 1'b0;
    step_to(14);
    chk("sw_rn14", {28'd0, o_reset_n}, 32'h0);
    step();
    chk("sw_rn15", {28'd0, o_reset_n}, 32'h1);
    step_to(27);
    chk("sw_done27", {31'd0, o_done}, 32'h0);
    step();
    chk("sw_done28", {31'd0, o_done}, 32'h1);

    // Software re-sequence out of ERROR
    mask = 4'b1011;
    do_reset();
    step_to(25);
    chk("err_set", {31'd0, o_error}, 32'h1);
    chk("err_dom", {30'd0, o_err_domain}, 32'h2);
    mask = 4'b1111;
    i_sw_reset = 1'b1;
    step();
    i_sw_reset = 1'b0;
    chk("errsw_err", {31'd0, o_error}, 32'h0);
    chk("errsw_dom", {30'd0, o_err_domain}, 32'h0);
    chk("errsw_rn", {28'd0, o_reset_n}, 32'h0);
    step_to(29);
    chk("errsw_rn29", {28'd0, o_reset_n}, 32'h0);
    step();
    chk("errsw_rn30", {28'd0, o_reset_n}, 32'h1);
    step_to(42);
    chk("errsw_done42", {31'd0, o_done}, 32'h0);
    step();
    chk("errsw_done43", {31'd0, o_done}, 32'h1);
    chk("errsw_err43", {31'd0, o_error}, 32'h0);

    // Asynchronous reset between edges 13 and 14
    do_reset();
    step_to(13);
    chk("async_rn13", {28'd0, o_reset_n}, 32'h7);
    #3 i_reset = 1'b1;
    #1;
    chk("async_rn", {28'd0, o_reset_n}, 32'h0);
    chk("async_done", {31'd0, o_done}, 32'h0);
    do_reset();
    step_to(3);
    chk("async_re3", {28'd0, o_reset_n}, 32'h0);
    step();
    chk("async_re4", {28'd0, o_reset_n}, 32'h1);

    // Testmode with the clock stopped, then running
    @(negedge clock);
    clk_en = 1'b0;
    testmode = 1'b1;
    i_reset = 1'b1;
    #2;
    chk("tm_rst1", {28'd0, o_reset_n}, 32'h0);
    i_reset = 1'b0;
    #2;
    chk("tm_rst0", {28'd0, o_reset_n}, 32'hf);
    i_reset = 1'b1;
    #2;
    chk("tm_rst1b", {28'd0, o_reset_n}, 32'h0);
    i_reset = 1'b0;
    #2;
    chk("tm_rst0b", {28'd0, o_reset_n}, 32'hf);
    chk("tm_done0", {31'd0, o_done}, 32'h0);
    edge_cnt = 0;
    clk_en = 1'b1;
    step_to(16);
    chk("tm_done16", {31'd0, o_done}, 32'h0);
    step();
    chk("tm_done17", {31'd0, o_done}, 32'h1);
    chk("tm_err17", {31'd0, o_error}, 32'h0);
    i_reset = 1'b1;
    step();
    testmode = 1'b0;

    // Timeout disabled: domain 1 ready arrives ~1000 cycles after release
    nt_mask = 4'b1101;
    @(negedge clock);
    nt_reset = 1'b0;
    edge_cnt = 0;
    step_to(8);
    chk("nt_rn8", {28'd0, nt_rn}, 32'h3);
    step_to(300);
    chk("nt_err300", {31'd0, nt_err}, 32'h0);
    chk("nt_rn300", {28'd0, nt_rn}, 32'h3);
    step_to(1008);
    chk("nt_err1008", {31'd0, nt_err}, 32'h0);
    nt_mask = 4'b1111;
    step_to(1011);
    chk("nt_rn1011", {28'd0, nt_rn}, 32'h3);
    step();
    chk("nt_rn1012", {28'd0, nt_rn}, 32'h7);
    step_to(1017);
    chk("nt_done1017", {31'd0, nt_done}, 32'h1);
    chk("nt_err1017", {31'd0, nt_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kw_reset_sequencer.md
# kw_reset_sequencer

Sequences release of DOMAINS downstream reset domains in fixed order (domain 0 first) after the global reset, waiting for each domain to report ready before releasing the next. Sits between the per-clock-domain reset synchronizers and the subsystems they feed. It supports software re-sequencing, a per-domain ready timeout, and a testmode bypass.

## Interface
- DOMAINS, 4: number of sequenced reset outputs; ≥2
- HOLD_CYCLES, 16: cycles all domains stay in reset before domain 0 is released; ≥1
- DELAY, 8: cycles from sampling ready[k] to releasing domain k+1; ≥1
- TIMEOUT, 255: max cycles to wait for ready[k] after release; 0 disables timeout

- clock  in  1  single clock; all logic is on its rising edge
- i_reset  in  1  reset, asynchronous, active-high
- testmode  in  1  1 = bypass sequencing on o_reset_n
- i_sw_reset  in  1  synchronous re-sequence request, level-sensitive
- i_ready  in  DOMAINS  per-domain ready, synchronous to clock
- o_reset_n  out  DOMAINS  per-domain reset, active low
- o_done  out  1  all domains released and ready
- o_error  out  1  ready timeout occurred
- o_err_domain  out  IDX_W  index of the timed-out domain; IDX_W = max(1,$clog2(DOMAINS))

## Operation
- States: HOLD, WAIT_READY, GAP, DONE, ERROR. Reset state is HOLD.
- Registers: idx (IDX_W), cnt (width $clog2(max(HOLD_CYCLES,DELAY,TIMEOUT)+1)).
- Reset values (async, while i_reset=1): state=HOLD, idx=0, cnt=0, o_reset_n=0, o_done=0, o_error=0, o_err_domain=0.
- HOLD: all o_reset_n=0. cnt counts edges. On the HOLD_CYCLES-th edge:
  - set o_reset_n[0]=1, idx=0, cnt=0
  - go to WAIT_READY
- WAIT_READY: sample i_ready[idx] each edge.
  - If 1 and idx<DOMAINS-1: go to GAP, cnt=0.
  - If 1 and idx=DOMAINS-1: go to DONE, o_done=1.
  - Else if TIMEOUT≠0 and this is the TIMEOUT-th edge since release: go to ERROR with o_error=1, o_err_domain=idx, all o_reset_n=0.
- GAP: on the DELAY-th edge, idx=idx+1, o_reset_n[idx+1]=1, go to WAIT_READY.
- DONE: hold outputs. i_ready is ignored; a domain dropping ready is not monitored.
- ERROR: hold until i_sw_reset or i_reset.
- Only i_ready[idx] in WAIT_READY is ever sampled.
- Released domains stay released (bit stays 1) until HOLD or ERROR is entered.
- i_sw_reset=1 at any edge, any state, has highest priority over every other transition:
  - o_reset_n=0, o_done=0, o_error=0, o_err_domain=0, cnt=0, idx=0
  - state=HOLD
  - While it stays high, cnt stays 0. HOLD counting starts at the first edge with it low.
- testmode=1: o_reset_n = {DOMAINS{~i_reset}} combinationally. The FSM, o_done and o_error run unchanged underneath. testmode is static during functional operation.

## Timing
- Edge 1 is the first rising edge with i_reset=0.
- o_reset_n[0] rises after edge HOLD_CYCLES.
- If i_ready[k] is sampled 1 at edge E (k<DOMAINS-1), o_reset_n[k+1] rises after edge E+DELAY.
- Earliest ready sample is the edge after release; i_ready high at release time does not count early.
- Last domain ready sampled at edge E: o_done=1 after edge E.
- Timeout: domain released at edge R, ready never seen → ERROR after edge R+TIMEOUT.
- If ready arrives at exactly edge R+TIMEOUT, ready wins and there is no error.
- i_reset assertion clears all outputs immediately, with no clock needed. Deassertion is sampled synchronously; the source is already synchronized upstream.
- All outputs except the testmode path are registered, with no combinational input→output path.

## Test plan
Parameters: DOMAINS=4, HOLD_CYCLES=4, DELAY=3, TIMEOUT=10; i_ready = o_reset_n (loopback) unless stated.
- Nominal: release i_reset.
  - o_reset_n becomes 0001 after edge 4, 0011 after 8, 0111 after 12, 1111 after 16.
  - o_done=1 after edge 17; o_error=0 throughout.
- Timeout: i_ready[2] tied 0.
  - o_reset_n=0111 after edge 12.
  - After edge 22: o_error=1, o_err_domain=2, o_reset_n=0000, o_done=0.
  - State held for 50 further cycles.
- Software re-sequence: i_sw_reset=1 on edges 10–11.
  - o_reset_n=0000 after edge 10.
  - Hold restarts at edge 12; 0001 after edge 15; o_done after edge 28.
  - The same pulse in ERROR clears o_error and re-runs the nominal sequence.
- Async reset mid-sequence: assert i_reset between edges 13 and 14.
  - o_reset_n=0000 and o_done=0 before edge 14, without a clock.
  - After deassertion the sequence restarts from edge 1.
- Testmode: testmode=1, toggle i_reset with the clock stopped.
  - o_reset_n follows ~i_reset on all bits.
  - With the clock running, o_done still rises after edge 17.
- Timeout disabled: TIMEOUT=0, i_ready[1] delayed 1000 cycles after release.
  - o_error stays 0.
  - o_reset_n[2] rises 3 edges after the ready sample.
